decode_exec_writeback: RTL and testbench
========================================

Name: decode_exec_writeback

Overview:
- Combines the core's three combinational and state-holding datapath pieces: the RV32I instruction decoder, the ALU executor and the register-file writeback.
- The decoder and ALU are purely combinational. The writeback owns the 31 architectural GPRs (x1..x31) and has two combinational read ports.
- Pipeline registers, bypass muxes, fetch and data memory live outside this block.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREGS, 32, architectural register count, including hardwired x0.

Ports:
- _clk  in  1  clock; GPR writes take effect on the rising edge.
- _reset  in  1  synchronous, active-high reset.
- _inst  in  32  instruction word to decode.
- rd_ / rs1_ / rs2_  out  5 each  inst[11:7] / inst[19:15] / inst[24:20].
- imm_  out  32  sign-extended immediate for the decoded format.
- sig_mem_we_  out  1  store (SW).
- sig_wb_we_  out  1  instruction writes rd.
- sig_wb_src_  out  2  writeback source: 0 = ALU, 1 = MEM, 2 = PCNEXT.
- sig_alu_src2_  out  1  ALU operand 2 select: 0 = REG, 1 = IMM.
- sig_alu_op_  out  4  ALU operation code (encodings below).
- sig_ebreak_  out  1  EBREAK decoded.
- sig_fetch_is_branch_  out  1  JAL, JALR or conditional branch.
- sig_fetch_base_gpr_  out  1  JALR (target base comes from rs1).
- sig_fetch_bcond_  out  1  conditional branch.
- sig_illegal_  out  1  unsupported encoding.
- _rs1_val / _rs2_val  in  32 each  ALU operands.
- _imm  in  32  immediate operand.
- _sig_src2  in  1  operand-2 select.
- _sig_op  in  4  ALU operation.
- res_  out  32  ALU result; res_[0] is the branch-taken flag.
- _we  in  1  writeback enable.
- _rd  in  5  writeback destination register.
- _res_alu / _res_mem / _res_pc  in  32 each  candidate writeback values; _res_pc is the instruction PC.
- _sig_src  in  2  writeback source select.
- _raddr1 / _raddr2  in  5 each  GPR read addresses.
- rdata1_ / rdata2_  out  32 each  GPR read data.

Behaviour:
- **Decoder:** combinational, zero latency.
  - OP, OP-IMM: wb_we=1, src ALU. OP-IMM selects IMM (I-type immediate; shift amount = inst[24:20]). inst[30] selects SUB/SRA.
  - LUI: wb_we=1, src ALU, IMM, op ADD, imm = {inst[31:12], 12'b0}, rs1_ forced to 0.
  - LW: wb_we=1, src MEM, IMM, ADD.
  - SW: mem_we=1, IMM, ADD, S-type immediate.
  - JAL: is_branch=1, wb_we=1, src PCNEXT, J-type immediate.
  - JALR: is_branch=1, base_gpr=1, wb_we=1, src PCNEXT, I-type immediate.
  - Bxx: is_branch=1, bcond=1, src2 REG, compare op chosen by funct3, B-type immediate.
  - EBREAK (0x00100073): ebreak=1.
  - Any other encoding (including AUIPC, byte/half loads and stores, FENCE, ECALL): sig_illegal_=1, all enables 0.
- **ALU op codes:** ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, EQ=10, NE=11, LT=12, GE=13, LTU=14, GEU=15.
- **Executor:** combinational.
  - op2 = _sig_src2 ? _imm : _rs2_val.
  - Shifts use op2[4:0].
  - Compare ops (SLT, SLTU, EQ..GEU) return {31'b0, cond}.
  - Arithmetic wraps modulo 2^32.
- **Writeback:**
  - On the rising edge with _we=1 and _rd≠0, GPR[_rd] gets: ALU → _res_alu; MEM → _res_mem; PCNEXT → _res_pc+4. _sig_src=3 writes nothing.
  - _rd=0 writes are discarded.
- **Reads:** combinational. Address 0 returns 0. A read of the register being written in the same cycle returns the new value (write-through bypass).
- **Reset:** while _reset=1 at a rising edge, all GPRs are cleared to 0 and any write that cycle is ignored. Reset mid-stream loses that write only. Decoder and ALU outputs depend only on their inputs and are unaffected by reset.

Test Plan:
- **Decode + ALU:** _inst=0x00500093 (addi x1,x0,5) → rd_=1, imm_=5, wb_we=1, src2=IMM, op=ADD. Feed _rs1_val=0, _imm=5 → res_=5.
- **Writeback + bypass:** after reset, _we=1, _rd=1, ALU src, _res_alu=5, _raddr1=1 → rdata1_=5 in the write cycle; the value persists after the edge. _rd=0 with 0xFFFF → rdata of x0 stays 0.
- **PCNEXT / JALR:** _inst=0x000080E7 (jalr x1,0(x1)) → is_branch=1, base_gpr=1, wb_src=2. Write with _res_pc=0x100 → x1=0x104.
- **Branch:** _inst=0x00208463 (beq x1,x2,8) → bcond=1, imm_=8, op=EQ. Operands 7,7 → res_=1; operands 7,8 → res_=0.
- **Shifts and signed compare:** SRA of 0x80000000 by 4 → 0xF8000000. SLT(-1,1)=1; SLTU(-1,1)=0.
- **EBREAK, illegal, reset:**
  - _inst=0x00100073 → sig_ebreak_=1.
  - _inst=0x00000017 (AUIPC) → sig_illegal_=1 with all enables 0.
  - _reset asserted alongside a write → all GPRs read 0 afterwards.

Source files
------------

// File: rtl/decode_exec_writeback_if.sv
// Bundle of the decoder, executor and writeback signal groups of decode_exec_writeback.
// The core side drives through master; the datapath block sits on slave.
interface decode_exec_writeback_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    // decoder
    logic [31:0]     dec_inst;
    logic [4:0]      dec_rd;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [XLEN-1:0] dec_imm;
    logic            dec_mem_we;
    logic            dec_wb_we;
    logic [1:0]      dec_wb_src;
    logic            dec_alu_src2;
    logic [3:0]      dec_alu_op;
    logic            dec_ebreak;
    logic            dec_is_branch;
    logic            dec_base_gpr;
    logic            dec_bcond;
    logic            dec_illegal;

    // executor
    logic [XLEN-1:0] ex_rs1_val;
    logic [XLEN-1:0] ex_rs2_val;
    logic [XLEN-1:0] ex_imm;
    logic            ex_src2;
    logic [3:0]      ex_op;
    logic [XLEN-1:0] ex_res;

    // writeback and register reads
    logic            wb_we;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_res_alu;
    logic [XLEN-1:0] wb_res_mem;
    logic [XLEN-1:0] wb_res_pc;
    logic [1:0]      wb_src;
    logic [AW-1:0]   wb_raddr1;
    logic [AW-1:0]   wb_raddr2;
    logic [XLEN-1:0] wb_rdata1;
    logic [XLEN-1:0] wb_rdata2;

    modport master (
        output dec_inst,
        input  dec_rd, dec_rs1, dec_rs2, dec_imm, dec_mem_we, dec_wb_we, dec_wb_src,
               dec_alu_src2, dec_alu_op, dec_ebreak, dec_is_branch, dec_base_gpr,
               dec_bcond, dec_illegal,
        output ex_rs1_val, ex_rs2_val, ex_imm, ex_src2, ex_op,
        input  ex_res,
        output wb_we, wb_rd, wb_res_alu, wb_res_mem, wb_res_pc, wb_src, wb_raddr1, wb_raddr2,
        input  wb_rdata1, wb_rdata2
    );

    modport slave (
        input  dec_inst,
        output dec_rd, dec_rs1, dec_rs2, dec_imm, dec_mem_we, dec_wb_we, dec_wb_src,
               dec_alu_src2, dec_alu_op, dec_ebreak, dec_is_branch, dec_base_gpr,
               dec_bcond, dec_illegal,
        input  ex_rs1_val, ex_rs2_val, ex_imm, ex_src2, ex_op,
        output ex_res,
        input  wb_we, wb_rd, wb_res_alu, wb_res_mem, wb_res_pc, wb_src, wb_raddr1, wb_raddr2,
        output wb_rdata1, wb_rdata2
    );
endinterface

// File: rtl/decode_exec_writeback.sv
// RV32I decoder and ALU (both combinational) plus the x1..x31 register file
// with two combinational read ports and write-through bypass.
module decode_exec_writeback #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    decode_exec_writeback_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SLL = 4'd2,  OP_SLT = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4,  OP_XOR  = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8,  OP_AND  = 4'd9,  OP_EQ  = 4'd10, OP_NE  = 4'd11;
    localparam logic [3:0] OP_LT   = 4'd12, OP_GE   = 4'd13, OP_LTU = 4'd14, OP_GEU = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] SRC_ALU = 2'd0, SRC_MEM = 2'd1, SRC_PC = 2'd2;

    // ---------------------------------------------------------------- decoder
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        shift_ok;

    assign inst   = bus.dec_inst;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Immediate shifts only allow funct7 0 (and 0x20 for SRAI)
    assign shift_ok = (funct3 == 3'b001) ? (funct7 == 7'h00) :
                      (funct3 == 3'b101) ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1;

    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? OP_SUB : OP_ADD;
            3'b001:  arith_op = OP_SLL;
            3'b010:  arith_op = OP_SLT;
            3'b011:  arith_op = OP_SLTU;
            3'b100:  arith_op = OP_XOR;
            3'b101:  arith_op = alt ? OP_SRA : OP_SRL;
            3'b110:  arith_op = OP_OR;
            default: arith_op = OP_AND;
        endcase
    endfunction

    always_comb begin
        bus.dec_rd        = inst[11:7];
        bus.dec_rs1       = inst[19:15];
        bus.dec_rs2       = inst[24:20];
        bus.dec_imm       = '0;
        bus.dec_mem_we    = 1'b0;
        bus.dec_wb_we     = 1'b0;
        bus.dec_wb_src    = SRC_ALU;
        bus.dec_alu_src2  = 1'b0;
        bus.dec_alu_op    = OP_ADD;
        bus.dec_ebreak    = 1'b0;
        bus.dec_is_branch = 1'b0;
        bus.dec_base_gpr  = 1'b0;
        bus.dec_bcond     = 1'b0;
        bus.dec_illegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    bus.dec_wb_we  = 1'b1;
                    bus.dec_alu_op = arith_op(funct3, inst[30]);
                end else begin
                    bus.dec_illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if (shift_ok) begin
                    bus.dec_wb_we    = 1'b1;
                    bus.dec_alu_src2 = 1'b1;
                    bus.dec_imm      = imm_i;
                    bus.dec_alu_op   = arith_op(funct3, funct3 == 3'b101 && inst[30]);
                end else begin
                    bus.dec_illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                bus.dec_wb_we    = 1'b1;
                bus.dec_alu_src2 = 1'b1;
                bus.dec_imm      = imm_u;
                bus.dec_rs1      = 5'd0;
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    bus.dec_wb_we    = 1'b1;
                    bus.dec_wb_src   = SRC_MEM;
                    bus.dec_alu_src2 = 1'b1;
                    bus.dec_imm      = imm_i;
                end else begin
                    bus.dec_illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) begin
                    bus.dec_mem_we   = 1'b1;
                    bus.dec_alu_src2 = 1'b1;
                    bus.dec_imm      = imm_s;
                end else begin
                    bus.dec_illegal = 1'b1;
                end
            end
            OPC_JAL: begin
                bus.dec_is_branch = 1'b1;
                bus.dec_wb_we     = 1'b1;
                bus.dec_wb_src    = SRC_PC;
                bus.dec_alu_src2  = 1'b1;
                bus.dec_imm       = imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    bus.dec_is_branch = 1'b1;
                    bus.dec_base_gpr  = 1'b1;
                    bus.dec_wb_we     = 1'b1;
                    bus.dec_wb_src    = SRC_PC;
                    bus.dec_alu_src2  = 1'b1;
                    bus.dec_imm       = imm_i;
                end else begin
                    bus.dec_illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    bus.dec_illegal = 1'b1;
                end else begin
                    bus.dec_is_branch = 1'b1;
                    bus.dec_bcond     = 1'b1;
                    bus.dec_imm       = imm_b;
                    case (funct3)
                        3'b000:  bus.dec_alu_op = OP_EQ;
                        3'b001:  bus.dec_alu_op = OP_NE;
                        3'b100:  bus.dec_alu_op = OP_LT;
                        3'b101:  bus.dec_alu_op = OP_GE;
                        3'b110:  bus.dec_alu_op = OP_LTU;
                        default: bus.dec_alu_op = OP_GEU;
                    endcase
                end
            end
            OPC_SYSTEM: begin
                if (inst == 32'h0010_0073) bus.dec_ebreak  = 1'b1;
                else                       bus.dec_illegal = 1'b1;
            end
            default: bus.dec_illegal = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------- executor
    logic [XLEN-1:0] op1, op2;
    logic [4:0]      shamt;

    assign op1   = bus.ex_rs1_val;
    assign op2   = bus.ex_src2 ? bus.ex_imm : bus.ex_rs2_val;
    assign shamt = op2[4:0];

    always_comb begin
        case (bus.ex_op)
            OP_ADD:  bus.ex_res = op1 + op2;
            OP_SUB:  bus.ex_res = op1 - op2;
            OP_SLL:  bus.ex_res = op1 << shamt;
            OP_SLT:  bus.ex_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLTU: bus.ex_res = {{(XLEN-1){1'b0}}, op1 < op2};
            OP_XOR:  bus.ex_res = op1 ^ op2;
            OP_SRL:  bus.ex_res = op1 >> shamt;
            OP_SRA:  bus.ex_res = $unsigned($signed(op1) >>> shamt);
            OP_OR:   bus.ex_res = op1 | op2;
            OP_AND:  bus.ex_res = op1 & op2;
            OP_EQ:   bus.ex_res = {{(XLEN-1){1'b0}}, op1 == op2};
            OP_NE:   bus.ex_res = {{(XLEN-1){1'b0}}, op1 != op2};
            OP_LT:   bus.ex_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_GE:   bus.ex_res = {{(XLEN-1){1'b0}}, $signed(op1) >= $signed(op2)};
            OP_LTU:  bus.ex_res = {{(XLEN-1){1'b0}}, op1 < op2};
            default: bus.ex_res = {{(XLEN-1){1'b0}}, op1 >= op2};
        endcase
    end

    // ---------------------------------------------------------------- writeback
    logic [XLEN-1:0] gpr_reg [NREGS];
    logic [XLEN-1:0] wr_data;
    logic            wr_en;

    always_comb begin
        case (bus.wb_src)
            SRC_ALU: wr_data = bus.wb_res_alu;
            SRC_MEM: wr_data = bus.wb_res_mem;
            SRC_PC:  wr_data = bus.wb_res_pc + XLEN'(4);
            default: wr_data = '0;
        endcase
    end

    // Gating on reset keeps a dropped write out of the bypass path as well
    assign wr_en = bus.wb_we && (bus.wb_rd != '0) && (bus.wb_src != 2'd3) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) gpr_reg[i] <= '0;
        end else if (wr_en) begin
            gpr_reg[bus.wb_rd] <= wr_data;
        end
    end

    logic [AW-1:0]   raddr [2];
    logic [XLEN-1:0] rdata [2];

    assign raddr[0]      = bus.wb_raddr1;
    assign raddr[1]      = bus.wb_raddr2;
    assign bus.wb_rdata1 = rdata[0];
    assign bus.wb_rdata2 = rdata[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_read
        assign rdata[gi] = (raddr[gi] == '0)                   ? '0      :
                           (wr_en && raddr[gi] == bus.wb_rd)   ? wr_data :
                                                                 gpr_reg[raddr[gi]];
    end
endmodule

// File: tb/tb_decode_exec_writeback.sv
// Randomized scoreboard bench for decode_exec_writeback: stimulus pushes expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_decode_exec_writeback;
    localparam int K_RD = 0, K_RS1 = 1, K_RS2 = 2, K_IMM = 3, K_MEMWE = 4, K_WBWE = 5;
    localparam int K_WBSRC = 6, K_SRC2 = 7, K_OP = 8, K_EBREAK = 9, K_ISBR = 10;
    localparam int K_BASE = 11, K_BCOND = 12, K_ILL = 13, K_RES = 14, K_RD1 = 15, K_RD2 = 16;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    typedef struct {
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        mem_we, wb_we;
        logic [1:0]  wb_src;
        logic        src2;
        logic [3:0]  op;
        logic        ebreak, is_branch, base_gpr, bcond, illegal;
    } dec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_txn   = 0;
    exp_t sb[$];
    logic [31:0] ref_gpr [32];

    decode_exec_writeback_if #(.XLEN(32), .NREGS(32)) bus ();

    decode_exec_writeback #(.XLEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_RD:     actual = 32'(bus.dec_rd);
            K_RS1:    actual = 32'(bus.dec_rs1);
            K_RS2:    actual = 32'(bus.dec_rs2);
            K_IMM:    actual = bus.dec_imm;
            K_MEMWE:  actual = 32'(bus.dec_mem_we);
            K_WBWE:   actual = 32'(bus.dec_wb_we);
            K_WBSRC:  actual = 32'(bus.dec_wb_src);
            K_SRC2:   actual = 32'(bus.dec_alu_src2);
            K_OP:     actual = 32'(bus.dec_alu_op);
            K_EBREAK: actual = 32'(bus.dec_ebreak);
            K_ISBR:   actual = 32'(bus.dec_is_branch);
            K_BASE:   actual = 32'(bus.dec_base_gpr);
            K_BCOND:  actual = 32'(bus.dec_bcond);
            K_ILL:    actual = 32'(bus.dec_illegal);
            K_RES:    actual = bus.ex_res;
            K_RD1:    actual = bus.wb_rdata1;
            K_RD2:    actual = bus.wb_rdata2;
            default:  actual = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t it;
            logic [31:0] act;
            it  = sb.pop_front();
            act = actual(it.kind);
            n_tests++;
            if (act !== it.exp) begin
                n_fail++;
                $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", it.name, act, it.exp, $time);
            end
        end
    end

    task automatic push(input int kind, input logic [31:0] exp, input string name);
        exp_t it;
        it.kind = kind;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- reference models
    function automatic dec_t decode_ref(input logic [31:0] inst);
        dec_t d;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] si, ii, ss, bb, uu, jj;
        int          arith_tab [8];
        int          br_tab [8];
        arith_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
        br_tab    = '{10, 11, -1, -1, 12, 13, 14, 15};
        opc = inst[6:0];
        f3  = inst[14:12];
        f7  = inst[31:25];
        si  = inst;
        ii  = $unsigned($signed(si) >>> 20);
        ss  = (ii & 32'hFFFF_FFE0) | 32'(inst[11:7]);
        bb  = ($unsigned($signed(si) >>> 19) & 32'hFFFF_F000) | (32'(inst[7]) << 11)
            | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
        uu  = inst & 32'hFFFF_F000;
        jj  = ($unsigned($signed(si) >>> 11) & 32'hFFF0_0000) | (inst & 32'h000F_F000)
            | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
        d = '{rd: inst[11:7], rs1: inst[19:15], rs2: inst[24:20], imm: 32'h0, mem_we: 1'b0,
              wb_we: 1'b0, wb_src: 2'd0, src2: 1'b0, op: 4'd0, ebreak: 1'b0, is_branch: 1'b0,
              base_gpr: 1'b0, bcond: 1'b0, illegal: 1'b0};
        if (opc == 7'h33 && (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)))) begin
            d.wb_we = 1'b1;
            d.op    = (f7 == 7'h20) ? ((f3 == 0) ? 4'd1 : 4'd7) : 4'(arith_tab[f3]);
        end else if (opc == 7'h13 && !(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 7'h20)) begin
            d.wb_we = 1'b1;
            d.src2  = 1'b1;
            d.imm   = ii;
            d.op    = (f3 == 5 && f7 == 7'h20) ? 4'd7 : 4'(arith_tab[f3]);
        end else if (opc == 7'h37) begin
            d.wb_we = 1'b1; d.src2 = 1'b1; d.imm = uu; d.rs1 = 5'd0;
        end else if (opc == 7'h03 && f3 == 2) begin
            d.wb_we = 1'b1; d.wb_src = 2'd1; d.src2 = 1'b1; d.imm = ii;
        end else if (opc == 7'h23 && f3 == 2) begin
            d.mem_we = 1'b1; d.src2 = 1'b1; d.imm = ss;
        end else if (opc == 7'h6F) begin
            d.is_branch = 1'b1; d.wb_we = 1'b1; d.wb_src = 2'd2; d.src2 = 1'b1; d.imm = jj;
        end else if (opc == 7'h67 && f3 == 0) begin
            d.is_branch = 1'b1; d.base_gpr = 1'b1; d.wb_we = 1'b1; d.wb_src = 2'd2;
            d.src2 = 1'b1; d.imm = ii;
        end else if (opc == 7'h63 && br_tab[f3] >= 0) begin
            d.is_branch = 1'b1; d.bcond = 1'b1; d.imm = bb; d.op = 4'(br_tab[f3]);
        end else if (inst == 32'h0010_0073) begin
            d.ebreak = 1'b1;
        end else begin
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
        int          sh;
        longint      sa, sb_;
        sh  = int'(b % 32);
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return 32'(sa < sb_);
            4:  return 32'(a < b);
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            8:  return a | b;
            9:  return a & b;
            10: return 32'(a == b);
            11: return 32'(a != b);
            12: return 32'(sa < sb_);
            13: return 32'(sa >= sb_);
            14: return 32'(a < b);
            default: return 32'(a >= b);
        endcase
    endfunction

    task automatic push_decode(input dec_t d);
        push(K_RD, 32'(d.rd), "dec_rd");
        push(K_RS1, 32'(d.rs1), "dec_rs1");
        push(K_RS2, 32'(d.rs2), "dec_rs2");
        push(K_IMM, d.imm, "dec_imm");
        push(K_MEMWE, 32'(d.mem_we), "dec_mem_we");
        push(K_WBWE, 32'(d.wb_we), "dec_wb_we");
        push(K_WBSRC, 32'(d.wb_src), "dec_wb_src");
        push(K_SRC2, 32'(d.src2), "dec_alu_src2");
        push(K_OP, 32'(d.op), "dec_alu_op");
        push(K_EBREAK, 32'(d.ebreak), "dec_ebreak");
        push(K_ISBR, 32'(d.is_branch), "dec_is_branch");
        push(K_BASE, 32'(d.base_gpr), "dec_base_gpr");
        push(K_BCOND, 32'(d.bcond), "dec_bcond");
        push(K_ILL, 32'(d.illegal), "dec_illegal");
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic src2);
        bus.ex_op      = op;
        bus.ex_rs1_val = a;
        bus.ex_rs2_val = b;
        bus.ex_imm     = imm;
        bus.ex_src2    = src2;
    endtask

    // One writeback/read cycle; the model commits first so same-cycle reads see the new value
    task automatic wb_cycle(input logic rst, input logic we, input logic [4:0] rd, input logic [1:0] src,
                            input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                            input logic [4:0] ra1, input logic [4:0] ra2, input string tag);
        step();
        reset          = rst;
        bus.wb_we      = we;
        bus.wb_rd      = rd;
        bus.wb_src     = src;
        bus.wb_res_alu = alu;
        bus.wb_res_mem = mem;
        bus.wb_res_pc  = pc;
        bus.wb_raddr1  = ra1;
        bus.wb_raddr2  = ra2;
        if (rst) begin
            for (int i = 0; i < 32; i++) ref_gpr[i] = 32'h0;
        end else begin
            if (we && rd != 0 && src != 2'd3)
                ref_gpr[rd] = (src == 2'd0) ? alu : (src == 2'd1) ? mem : pc + 32'd4;
            push(K_RD1, ref_gpr[ra1], {tag, "_rdata1"});
            push(K_RD2, ref_gpr[ra2], {tag, "_rdata2"});
        end
        n_txn++;
        $display("[TB] txn %0d %s rst=%0b we=%0b rd=%0d src=%0d ra1=%0d ra2=%0d", n_txn, tag, rst, we, rd, src, ra1, ra2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_t d;
        logic [31:0] inst;
        reset = 1'b1;
        bus.dec_inst = 32'h0000_0013;
        drive_alu(4'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_src = 2'd0;
        bus.wb_res_alu = 32'h0; bus.wb_res_mem = 32'h0; bus.wb_res_pc = 32'h0;
        bus.wb_raddr1 = 5'd0; bus.wb_raddr2 = 5'd0;
        for (int i = 0; i < 32; i++) ref_gpr[i] = 32'h0;
        step();
        step();

        // Reset state
        wb_cycle(1'b0, 1'b0, 5'd0, 2'd0, 0, 0, 0, 5'd5, 5'd31, "reset_state");

        // addi x1,x0,5 decode and ADD
        step();
        bus.dec_inst = 32'h0050_0093;
        drive_alu(4'd0, 32'h0, 32'h1234, 32'd5, 1'b1);
        push(K_RD, 32'd1, "addi_rd"); push(K_IMM, 32'd5, "addi_imm");
        push(K_WBWE, 32'd1, "addi_wb_we"); push(K_SRC2, 32'd1, "addi_src2");
        push(K_OP, 32'd0, "addi_op"); push(K_RES, 32'd5, "addi_res");

        // Writeback + bypass, persistence, x0 discard
        wb_cycle(1'b0, 1'b1, 5'd1, 2'd0, 32'd5, 32'h0, 32'h0, 5'd1, 5'd2, "wb_bypass");
        wb_cycle(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, "wb_persist");
        wb_cycle(1'b0, 1'b1, 5'd0, 2'd0, 32'hFFFF, 32'h0, 32'h0, 5'd0, 5'd1, "wb_x0");
        wb_cycle(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd1, "wb_x0_after");

        // jalr x1,0(x1) and PCNEXT write
        step();
        bus.dec_inst = 32'h0000_80E7;
        push(K_ISBR, 32'd1, "jalr_is_branch"); push(K_BASE, 32'd1, "jalr_base_gpr");
        push(K_WBSRC, 32'd2, "jalr_wb_src");
        wb_cycle(1'b0, 1'b1, 5'd1, 2'd2, 32'h0, 32'h0, 32'h100, 5'd2, 5'd3, "wb_pcnext");
        wb_cycle(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, "wb_pcnext_read");
        push(K_RD1, 32'h104, "pcnext_x1_const");

        // beq x1,x2,8 and the two compare outcomes
        step();
        bus.dec_inst = 32'h0020_8463;
        drive_alu(4'd10, 32'd7, 32'd7, 32'd8, 1'b0);
        push(K_BCOND, 32'd1, "beq_bcond"); push(K_IMM, 32'd8, "beq_imm");
        push(K_OP, 32'd10, "beq_op"); push(K_RES, 32'd1, "beq_taken");
        step();
        drive_alu(4'd10, 32'd7, 32'd8, 32'd8, 1'b0);
        push(K_RES, 32'd0, "beq_not_taken");

        // Shift and signed/unsigned compare corners
        step();
        drive_alu(4'd7, 32'h8000_0000, 32'd4, 32'h0, 1'b0);
        push(K_RES, 32'hF800_0000, "sra_sign");
        step();
        drive_alu(4'd3, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
        push(K_RES, 32'd1, "slt_neg");
        step();
        drive_alu(4'd4, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
        push(K_RES, 32'd0, "sltu_big");

        // EBREAK and AUIPC
        step();
        bus.dec_inst = 32'h0010_0073;
        push(K_EBREAK, 32'd1, "ebreak"); push(K_ILL, 32'd0, "ebreak_legal");
        step();
        bus.dec_inst = 32'h0000_0017;
        push(K_ILL, 32'd1, "auipc_illegal"); push(K_WBWE, 32'd0, "auipc_wb_we");
        push(K_MEMWE, 32'd0, "auipc_mem_we"); push(K_ISBR, 32'd0, "auipc_is_branch");

        // Reset alongside a write clears everything
        wb_cycle(1'b0, 1'b1, 5'd3, 2'd1, 32'h0, 32'hAAAA, 32'h0, 5'd3, 5'd1, "pre_reset");
        wb_cycle(1'b1, 1'b1, 5'd4, 2'd0, 32'h55, 32'h0, 32'h0, 5'd4, 5'd3, "reset_write");
        wb_cycle(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd3, "post_reset");
        push(K_RD1, 32'h0, "post_reset_x4_const");
        wb_cycle(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd31, "post_reset2");

        // Random decode
        for (int i = 0; i < 200; i++) begin
            logic [6:0] opcs [10];
            opcs = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63, 7'h73, 7'h17};
            step();
            inst = $urandom;
            if (i % 11 != 10) inst[6:0] = opcs[$urandom_range(0, 9)];
            if ($urandom_range(0, 2) != 0) inst[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            if (i % 25 == 0) inst = 32'h0010_0073;
            bus.dec_inst = inst;
            d = decode_ref(inst);
            push_decode(d);
            n_txn++;
            $display("[TB] txn %0d decode inst=0x%08h", n_txn, inst);
        end

        // Random ALU
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, b, imm;
            logic        s2;
            int          op;
            step();
            op  = $urandom_range(0, 15);
            a   = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
            b   = (i % 5 == 0) ? a : $urandom;
            imm = $urandom;
            s2  = 1'($urandom_range(0, 1));
            drive_alu(4'(op), a, b, imm, s2);
            push(K_RES, alu_ref(op, a, s2 ? imm : b), "alu_rand");
            n_txn++;
            $display("[TB] txn %0d alu op=%0d a=0x%08h b=0x%08h imm=0x%08h src2=%0b", n_txn, op, a, b, imm, s2);
        end

        // Random writeback/read traffic with occasional reset
        for (int i = 0; i < 250; i++) begin
            wb_cycle(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) != 0),
                     5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                     $urandom, $urandom, $urandom,
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "wb_rand");
        end

        reset = 1'b0;
        step();
        step();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
